// File: rtl/ofm_postproc_pkg.sv
// rtl/ofm_postproc_pkg.sv - shared constants and helpers for the OFM post-processing pipeline
// Contents: leaky ReLU slope (LEAKY_MUL / 2^LEAKY_SHIFT), shift clamp limit,
// default accumulator-derived widths, width helpers and the shift clamp function.
package ofm_postproc_pkg;

    localparam int LEAKY_MUL     = 13;
    localparam int LEAKY_SHIFT   = 7;
    localparam int SHIFT_MAX     = 16;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int SUM_W         = ACC_WIDTH_DEF + 1;
    localparam int RND_W         = ACC_WIDTH_DEF + 2;

    function automatic int sum_width(input int acc_w);
        return acc_w + 1;
    endfunction

    function automatic int rnd_width(input int acc_w);
        return acc_w + 2;
    endfunction

    // Shift amounts above SHIFT_MAX behave exactly like SHIFT_MAX.
    function automatic logic [4:0] clamp_shift(input logic [4:0] s);
        return (s > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : s;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - combinational single-lane requantization and activation math
// Two independent paths; the caller registers between them.
//   sum, shift_amt -> r_out : (sum + rnd) >>> shift, rounding half toward +inf
//   r_in, leaky_en -> q_out : optional leaky ReLU then saturation to DATA_WIDTH
//   clipped (OFM_POSTPROC_SAT_CNT_EN only) : q_out was saturated
module requant_lane
    import ofm_postproc_pkg::*;
#(
    parameter int SUM_WIDTH  = SUM_W,
    parameter int RND_WIDTH  = RND_W,
    parameter int DATA_WIDTH = 8
) (
    input  logic [SUM_WIDTH-1:0]  sum,
    input  logic [4:0]            shift_amt,
    output logic [RND_WIDTH-1:0]  r_out,
    input  logic [RND_WIDTH-1:0]  r_in,
    input  logic                  leaky_en,
`ifdef OFM_POSTPROC_SAT_CNT_EN
    output logic                  clipped,
`endif
    output logic [DATA_WIDTH-1:0] q_out
);

    // Headroom for r * LEAKY_MUL without overflow.
    localparam int PW     = RND_WIDTH + 6;
    localparam int QMAX_I = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int QMIN_I = -QMAX_I - 1;

    logic [4:0]                  sh;
    logic signed [RND_WIDTH-1:0] sum_x;
    logic signed [RND_WIDTH-1:0] rnd;
    logic signed [RND_WIDTH-1:0] biased;

    always_comb begin
        sh     = clamp_shift(shift_amt);
        sum_x  = RND_WIDTH'($signed(sum));
        rnd    = (sh == 5'd0) ? '0 : (RND_WIDTH'(1) << (sh - 5'd1));
        biased = sum_x + rnd;
        r_out  = biased >>> sh;
    end

    logic signed [PW-1:0] r_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] act;
    logic                 sat_hi;
    logic                 sat_lo;

    always_comb begin
        r_x    = PW'($signed(r_in));
        prod   = r_x * PW'(LEAKY_MUL);
        // Arithmetic shift floors the negative product.
        act    = (leaky_en && (r_x < 0)) ? (prod >>> LEAKY_SHIFT) : r_x;
        sat_hi = act > PW'(QMAX_I);
        sat_lo = act < PW'(QMIN_I);
        q_out  = act[DATA_WIDTH-1:0];
        if (sat_hi) begin
            q_out = DATA_WIDTH'(QMAX_I);
        end else if (sat_lo) begin
            q_out = DATA_WIDTH'(QMIN_I);
        end
    end

`ifdef OFM_POSTPROC_SAT_CNT_EN
    assign clipped = sat_hi | sat_lo;
`endif

endmodule

// File: rtl/ofm_postproc.sv
// rtl/ofm_postproc.sv - bias/requant/leaky-ReLU/int8 post-processing of PE array rows
// Elastic 3-stage valid/ready pipeline: S1 bias add, S2 rounding shift, S3 activation+saturation.
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_data (SYSTOLIC_SIZE x ACC_WIDTH);
// bias_we/bias_addr/bias_din lane bias writes; shift_amt, leaky_en frame-static controls;
// out_valid/out_ready/out_data (SYSTOLIC_SIZE x DATA_WIDTH); out_last final beat of frame;
// frame_done pulse after the out_last handshake.
// Optional macro OFM_POSTPROC_SAT_CNT_EN adds sat_count (clipped lanes per frame).
module ofm_postproc
    import ofm_postproc_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH    = 8,
    parameter int OUT_WORDS     = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]    in_data,
    input  logic                                  bias_we,
    input  logic [$clog2(SYSTOLIC_SIZE)-1:0]      bias_addr,
    input  logic [ACC_WIDTH-1:0]                  bias_din,
    input  logic [4:0]                            shift_amt,
    input  logic                                  leaky_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   out_data,
    output logic                                  out_last,
`ifdef OFM_POSTPROC_SAT_CNT_EN
    output logic [31:0]                           sat_count,
`endif
    output logic                                  frame_done
);

    localparam int SW = sum_width(ACC_WIDTH);
    localparam int RW = rnd_width(ACC_WIDTH);
    localparam int CW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_WORDS - 1);

    logic [ACC_WIDTH-1:0] bias    [SYSTOLIC_SIZE];
    logic [SW-1:0]        sum_nxt [SYSTOLIC_SIZE];
    logic [SW-1:0]        s1_sum  [SYSTOLIC_SIZE];
    logic [RW-1:0]        r_nxt   [SYSTOLIC_SIZE];
    logic [RW-1:0]        s2_r    [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] q_nxt;

    logic v1, v2, v3;
    logic en1, en2, en3;
    logic out_hs;
    logic [CW-1:0] cnt;

    // A stage may load when it is empty or its content moves on this edge.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    assign out_valid = v3;
    assign out_hs    = v3 && out_ready;
    assign out_last  = v3 && (cnt == CNT_LAST);

    always_comb begin
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            sum_nxt[i] = SW'($signed(in_data[i*ACC_WIDTH +: ACC_WIDTH])) + SW'($signed(bias[i]));
        end
    end

`ifdef OFM_POSTPROC_SAT_CNT_EN
    localparam int NW = $clog2(SYSTOLIC_SIZE + 1);
    logic [SYSTOLIC_SIZE-1:0] clip_nxt;
    logic [NW-1:0]            clip_cnt_nxt;
    logic [NW-1:0]            s3_clips;
    logic [32:0]              sat_sum;
`endif

    for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_lane
        requant_lane #(
            .SUM_WIDTH  (SW),
            .RND_WIDTH  (RW),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .sum        (s1_sum[g]),
            .shift_amt  (shift_amt),
            .r_out      (r_nxt[g]),
            .r_in       (s2_r[g]),
            .leaky_en   (leaky_en),
`ifdef OFM_POSTPROC_SAT_CNT_EN
            .clipped    (clip_nxt[g]),
`endif
            .q_out      (q_nxt[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            out_data   <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                bias[i]   <= '0;
                s1_sum[i] <= '0;
                s2_r[i]   <= '0;
            end
        end else begin
            if (bias_we) begin
                bias[bias_addr] <= bias_din;
            end
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sum <= sum_nxt;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    s2_r <= r_nxt;
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) begin
                    out_data <= q_nxt;
                end
            end
            if (out_hs) begin
                cnt <= out_last ? '0 : cnt + CW'(1);
            end
            frame_done <= out_hs && out_last;
        end
    end

`ifdef OFM_POSTPROC_SAT_CNT_EN
    always_comb begin
        clip_cnt_nxt = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            clip_cnt_nxt = clip_cnt_nxt + NW'(clip_nxt[i]);
        end
    end

    // The clear on frame_done and the add of a concurrent beat share one cycle.
    always_comb begin
        sat_sum = {1'b0, (frame_done ? 32'd0 : sat_count)} + (out_hs ? 33'(s3_clips) : 33'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_clips  <= '0;
            sat_count <= '0;
        end else begin
            if (en3 && v2) begin
                s3_clips <= clip_cnt_nxt;
            end
            sat_count <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_ofm_postproc.sv
// tb/tb_ofm_postproc.sv - directed self-checking bench for ofm_postproc
module tb_ofm_postproc;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         bias_we;
    logic [3:0]   bias_addr;
    logic [15:0]  bias_din;
    logic [4:0]   shift_amt;
    logic         leaky_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         frame_done;
`ifdef OFM_POSTPROC_SAT_CNT_EN
    logic [31:0]  sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] tx_q[$];
    logic [127:0] rx_data[$];
    logic         rx_last[$];
    logic         fd_obs[$], fd_exp[$], ir_obs[$], ir_exp[$], stab_ok[$];
    bit           pat[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    ofm_postproc #(
        .SYSTOLIC_SIZE (16),
        .ACC_WIDTH     (16),
        .DATA_WIDTH    (8),
        .OUT_WORDS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_din   (bias_din),
        .shift_amt  (shift_amt),
        .leaky_en   (leaky_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
`ifdef OFM_POSTPROC_SAT_CNT_EN
        .sat_count  (sat_count),
`endif
        .frame_done (frame_done)
    );

    function automatic logic [255:0] put(input logic [255:0] d, input int i, input int v);
        d[i*16 +: 16] = 16'(v);
        return d;
    endfunction

    function automatic int sl(input logic [127:0] w, input int i);
        logic signed [7:0] b;
        b = w[i*8 +: 8];
        return int'(b);
    endfunction

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic write_bias(input int addr, input int val);
        bias_we   = 1'b1;
        bias_addr = 4'(addr);
        bias_din  = 16'(val);
        @(posedge clk); #1;
        bias_we   = 1'b0;
    endtask

    task automatic send_one(input logic [255:0] d, output logic [127:0] got, output int lat);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        got = out_data;
    endtask

    task automatic stream(input int n, input bit stall);
        int sent, cyc;
        logic prev_last_hs, prev_stall, ihs, ohs;
        logic [127:0] prev_data;
        sent = 0; cyc = 0; prev_last_hs = 0; prev_stall = 0; prev_data = '0;
        rx_data.delete(); rx_last.delete();
        fd_obs.delete(); fd_exp.delete(); ir_obs.delete(); ir_exp.delete(); stab_ok.delete();
        while (rx_data.size() < n && cyc < 300) begin
            in_valid = (sent < n);
            if (sent < n) in_data = tx_q[sent];
            out_ready = stall ? pat[cyc % 16] : 1'b1;
            #1;
            fd_obs.push_back(frame_done);
            fd_exp.push_back(prev_last_hs);
            ir_obs.push_back(in_ready);
            ir_exp.push_back(!(((sent - rx_data.size()) == 3) && !out_ready));
            stab_ok.push_back(!prev_stall || (out_valid && out_data == prev_data));
            ihs = in_valid && in_ready;
            ohs = out_valid && out_ready;
            if (ohs) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
            end
            prev_last_hs = ohs && out_last;
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
            @(posedge clk); #1;
            bias_we = 1'b0;
            if (ihs) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fd_obs.push_back(frame_done);
        fd_exp.push_back(prev_last_hs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [255:0] d;
        logic [127:0] got;
        int lat;
        do_reset();
        write_bias(0, 24);
        shift_amt = 5'd3; leaky_en = 1'b0;
        d = '0; d = put(d, 0, 1000); d = put(d, 1, 40); d = put(d, 15, -40);
        send_one(d, got, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        n_checks++; if (sl(got, 0) !== 127) begin n_fail++; $display("FAIL basic_lane0: got %0d expected 127", sl(got, 0)); end
        n_checks++; if (sl(got, 1) !== 5) begin n_fail++; $display("FAIL basic_lane1: got %0d expected 5", sl(got, 1)); end
        n_checks++; if (sl(got, 15) !== -5) begin n_fail++; $display("FAIL basic_lane15: got %0d expected -5", sl(got, 15)); end
    endtask

    task automatic test_bias_timing();
        do_reset();
        shift_amt = 5'd0; leaky_en = 1'b0;
        tx_q.delete();
        tx_q.push_back(put('0, 2, 0));
        tx_q.push_back(put('0, 2, 0));
        bias_we = 1'b1; bias_addr = 4'd2; bias_din = 16'd7;
        stream(2, 1'b0);
        n_checks++; if (rx_data.size() !== 2) begin n_fail++; $display("FAIL biastime_count: got %0d expected 2", rx_data.size()); end
        if (rx_data.size() == 2) begin
            n_checks++; if (sl(rx_data[0], 2) !== 0) begin n_fail++; $display("FAIL biastime_same_cycle: got %0d expected 0", sl(rx_data[0], 2)); end
            n_checks++; if (sl(rx_data[1], 2) !== 7) begin n_fail++; $display("FAIL biastime_next_cycle: got %0d expected 7", sl(rx_data[1], 2)); end
        end
    endtask

    task automatic test_rounding();
        logic [255:0] d;
        logic [127:0] got;
        int lat;
        do_reset();
        leaky_en = 1'b0;
        write_bias(3, -16);
        write_bias(4, -32768);
        write_bias(5, 32767);
        shift_amt = 5'd2;
        d = '0; d = put(d, 0, 6); d = put(d, 1, -6); d = put(d, 3, 80);
        send_one(d, got, lat);
        n_checks++; if (sl(got, 0) !== 2) begin n_fail++; $display("FAIL round_6_s2: got %0d expected 2", sl(got, 0)); end
        n_checks++; if (sl(got, 1) !== -1) begin n_fail++; $display("FAIL round_neg6_s2: got %0d expected -1", sl(got, 1)); end
        n_checks++; if (sl(got, 3) !== 16) begin n_fail++; $display("FAIL round_80_bm16: got %0d expected 16", sl(got, 3)); end
        shift_amt = 5'd0;
        d = '0; d = put(d, 3, 80); d = put(d, 4, -32768); d = put(d, 5, 32767);
        send_one(d, got, lat);
        n_checks++; if (sl(got, 3) !== 64) begin n_fail++; $display("FAIL round_s0_64: got %0d expected 64", sl(got, 3)); end
        n_checks++; if (sl(got, 4) !== -128) begin n_fail++; $display("FAIL round_min_sat: got %0d expected -128", sl(got, 4)); end
        n_checks++; if (sl(got, 5) !== 127) begin n_fail++; $display("FAIL round_max_sat: got %0d expected 127", sl(got, 5)); end
        shift_amt = 5'd20;
        d = '0; d = put(d, 5, 32767);
        send_one(d, got, lat);
        n_checks++; if (sl(got, 5) !== 1) begin n_fail++; $display("FAIL round_shift_clamp: got %0d expected 1", sl(got, 5)); end
    endtask

    task automatic test_leaky();
        logic [255:0] d;
        logic [127:0] got;
        int lat;
        do_reset();
        shift_amt = 5'd0; leaky_en = 1'b1;
        d = '0; d = put(d, 0, -100); d = put(d, 1, -2000); d = put(d, 2, 50); d = put(d, 3, -1);
        send_one(d, got, lat);
        n_checks++; if (sl(got, 0) !== -11) begin n_fail++; $display("FAIL leaky_m100: got %0d expected -11", sl(got, 0)); end
        n_checks++; if (sl(got, 1) !== -128) begin n_fail++; $display("FAIL leaky_m2000: got %0d expected -128", sl(got, 1)); end
        n_checks++; if (sl(got, 2) !== 50) begin n_fail++; $display("FAIL leaky_pos: got %0d expected 50", sl(got, 2)); end
        n_checks++; if (sl(got, 3) !== -1) begin n_fail++; $display("FAIL leaky_m1: got %0d expected -1", sl(got, 3)); end
        leaky_en = 1'b0;
        send_one(d, got, lat);
        n_checks++; if (sl(got, 0) !== -100) begin n_fail++; $display("FAIL noleaky_m100: got %0d expected -100", sl(got, 0)); end
        n_checks++; if (sl(got, 1) !== -128) begin n_fail++; $display("FAIL noleaky_m2000: got %0d expected -128", sl(got, 1)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        shift_amt = 5'd0; leaky_en = 1'b0;
        tx_q.delete();
        for (int k = 0; k < 8; k++) tx_q.push_back(put(put('0, 0, k * 10 + 1), 7, -k));
        stream(8, 1'b1);
        n_checks++; if (rx_data.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", rx_data.size()); end
        for (int k = 0; k < rx_data.size(); k++) begin
            n_checks++; if (sl(rx_data[k], 0) !== k * 10 + 1) begin n_fail++; $display("FAIL bp_lane0 beat %0d: got %0d expected %0d", k, sl(rx_data[k], 0), k * 10 + 1); end
            n_checks++; if (sl(rx_data[k], 7) !== -k) begin n_fail++; $display("FAIL bp_lane7 beat %0d: got %0d expected %0d", k, sl(rx_data[k], 7), -k); end
        end
        for (int c = 0; c < ir_obs.size(); c++) begin
            n_checks++; if (ir_obs[c] !== ir_exp[c]) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b expected %b", c, ir_obs[c], ir_exp[c]); end
            n_checks++; if (stab_ok[c] !== 1'b1) begin n_fail++; $display("FAIL bp_stall_stable cycle %0d: got %b expected 1", c, stab_ok[c]); end
        end
    endtask

    task automatic test_framing();
        do_reset();
        shift_amt = 5'd0; leaky_en = 1'b0;
        tx_q.delete();
        for (int k = 0; k < 12; k++) tx_q.push_back(put('0, 0, k));
        stream(12, 1'b0);
        n_checks++; if (rx_data.size() !== 12) begin n_fail++; $display("FAIL frame_count: got %0d expected 12", rx_data.size()); end
        for (int k = 0; k < rx_last.size(); k++) begin
            n_checks++; if (rx_last[k] !== (k % 4 == 3)) begin n_fail++; $display("FAIL frame_last beat %0d: got %b expected %b", k + 1, rx_last[k], (k % 4 == 3)); end
        end
        for (int c = 0; c < fd_obs.size(); c++) begin
            n_checks++; if (fd_obs[c] !== fd_exp[c]) begin n_fail++; $display("FAIL frame_done cycle %0d: got %b expected %b", c, fd_obs[c], fd_exp[c]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        shift_amt = 5'd0; leaky_en = 1'b0;
        tx_q.delete();
        tx_q.push_back('0);
        tx_q.push_back('0);
        stream(2, 1'b0);
        write_bias(0, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = put('0, 0, 9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        tx_q.delete();
        for (int k = 0; k < 4; k++) tx_q.push_back(put('0, 0, 5));
        stream(4, 1'b0);
        n_checks++; if (rx_data.size() !== 4) begin n_fail++; $display("FAIL midrst_count: got %0d expected 4", rx_data.size()); end
        if (rx_data.size() == 4) begin
            n_checks++; if (sl(rx_data[0], 0) !== 5) begin n_fail++; $display("FAIL midrst_bias_cleared: got %0d expected 5", sl(rx_data[0], 0)); end
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (rx_last[k] !== (k == 3)) begin n_fail++; $display("FAIL midrst_last beat %0d: got %b expected %b", k + 1, rx_last[k], (k == 3)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; bias_we = 1'b0; bias_addr = '0;
        bias_din = '0; shift_amt = '0; leaky_en = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_bias_timing();
        test_rounding();
        test_leaky();
        test_back_to_back();
        test_framing();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofm_postproc.md
Name: ofm_postproc

Overview:
- Downstream of the PE array: consumes raw 16-bit per-filter accumulator rows (one lane per systolic column/filter) before they reach OFM memory.
- Per lane: bias add, rounding right-shift requantization, optional leaky ReLU, and int8 saturation.
- Output is a packed 128-bit word for the next layer's IFM buffer.
- Elastic 3-stage valid/ready pipeline with a per-frame word counter, so writeback can stall without losing data.

Parameters:
- SYSTOLIC_SIZE, 16, number of lanes (filters) per beat.
- ACC_WIDTH, 16, signed accumulator width per lane.
- DATA_WIDTH, 8, signed output width per lane.
- OUT_WORDS, 1024, beats per frame; sets the out_last position.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  SYSTOLIC_SIZE*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH], signed.
- bias_we  in  1  bias register write strobe.
- bias_addr  in  $clog2(SYSTOLIC_SIZE)  lane index for the bias write.
- bias_din  in  ACC_WIDTH  signed bias value.
- shift_amt  in  5  requant right-shift (0..16); static during a frame.
- leaky_en  in  1  enables leaky ReLU; static during a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  SYSTOLIC_SIZE*DATA_WIDTH  packed int8 lanes, same lane order as in_data.
- out_last  out  1  marks the final beat of a frame.
- frame_done  out  1  one-cycle pulse after the out_last handshake.

Behaviour:
- Reset: all stage valids, out_valid, out_last and frame_done are 0; out_data is 0; bias registers are 0; beat counter is 0. in_ready is 1 from the first cycle after reset. Reset mid-frame discards all in-flight beats.
- Handshake: a transfer occurs when valid&&ready on the same edge.
  - Stage k advances when its successor is empty or advancing.
  - in_ready = !v1 || advance1, combinational from the downstream state; no combinational path from in_valid.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Latency: 3 cycles from input handshake to out_valid with no stall. Full throughput is 1 beat per cycle.
- S1: sum_i = sext17(acc_i) + sext17(bias[i]); cannot overflow.
  - Bias is read at S1 capture.
  - A bias write becomes visible to beats captured in S1 on the cycle after bias_we.
- S2 (18-bit signed): r_i = (sum_i + rnd) >>> shift_amt.
  - rnd = 0 if shift_amt==0, else 1<<(shift_amt-1); this rounds half toward +inf.
  - shift_amt>16 is treated as 16.
- S3: if leaky_en and r_i<0, a_i = (r_i*13) >>> 7 (floor, slope ≈0.1016); else a_i = r_i.
  - Saturate a_i to [-128,127].
- Counter: increments on each output handshake.
  - out_last = out_valid && (cnt==OUT_WORDS-1).
  - On that handshake cnt wraps to 0 and frame_done pulses high on the next cycle.
  - OUT_WORDS==1 makes every beat last.
- Simultaneous input and output handshakes in one cycle are legal and keep full throughput.

Optional Feature:
- OFM_POSTPROC_SAT_CNT_EN: adds output sat_count (32-bit).
  - sat_count increments by the number of lanes clipped in S3 for each beat that completes its output handshake.
  - It saturates at 0xFFFFFFFF and clears on rst and on frame_done.
- Without the macro: no port, no counter logic.

Decomposition:
- Shared package ofm_postproc_pkg: LEAKY_MUL=13, LEAKY_SHIFT=7, SHIFT_MAX=16, widths derived from ACC_WIDTH (SUM_W=ACC_WIDTH+1, RND_W=ACC_WIDTH+2).
- Sub-module requant_lane: purely combinational single-lane S2/S3 math, instantiated SYSTOLIC_SIZE times. Pipeline registers, handshake and counter stay in the top.

Test Plan:
- Basic: bias[0]=24, acc0=1000, shift=3 -> sum 1024, r=128, lane0 out 127 (saturated) exactly 3 cycles after in handshake.
- Rounding: acc=6, bias=0, shift=2 -> 2. acc=80, bias=-16, shift=2 -> 16. acc=-32768, bias=-32768, shift=0 -> -128.
- Leaky: leaky_en=1, acc=-100, bias=0, shift=0 -> -11. Same with leaky_en=0 -> -100 then saturated to -100 (in range). acc=-2000 -> (-2000*13)>>>7=-204 -> -128.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1 randomly -> all 8 beats emerge in order, unchanged; in_ready drops only when all 3 stages are full and out_ready=0.
- Framing: OUT_WORDS=4, 9 beats -> out_last on beats 4 and 8; frame_done pulses the cycle after each; counter at 1 after beat 9.
- Reset mid-frame: 2 beats in flight, assert rst 1 cycle -> out_valid=0, cnt=0, biases 0. The next beat with acc=5, shift=0 -> 5, and out_last follows fresh counting.
